// File: rtl/design_bist_sequencer.sv
// Built-in self-test sequencer for the multiplexed user designs.
// Firmware programs a design mask, reset pulse count, step count and a fixed
// input stimulus over Wishbone. For every selected design the sequencer takes
// over the multiplexer: it selects the design, pulses its clock while in reset,
// then steps it with reset released and folds each sampled output word into a
// 32-bit MISR. It parks in HOLD until firmware reads the signature.
module design_bist_sequencer #(
    parameter int NUM_DESIGNS = 12,
    parameter int ADDR_W      = 4,
    parameter int IO_W        = 27,
    parameter int CNT_W       = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic [31:0]            wbs_dat_o,
    input  logic                   wbs_we_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    output logic                   wbs_ack_o,
    output logic                   ovr_en_o,
    output logic                   ovr_rst_o,
    output logic                   ovr_step_o,
    output logic                   ovr_clk_o,
    output logic [ADDR_W-1:0]      ovr_addr_o,
    output logic [IO_W-1:0]        ovr_io_o,
    input  logic [IO_W-1:0]        dso_cap_i,
    output logic                   done_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_SELECT = 3'd2,
        ST_RESET  = 3'd3,
        ST_RUN    = 3'd4,
        ST_HOLD   = 3'd5
    } state_t;

    // One MISR compression step (CRC-32 polynomial feedback plus sample).
    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [IO_W-1:0] cap);
        logic [31:0] fb;
        fb = sig[31] ? 32'h04C1_1DB7 : 32'h0000_0000;
        return {sig[30:0], 1'b0} ^ fb ^ {{(32-IO_W){1'b0}}, cap};
    endfunction

    // Index of the lowest set bit; the scan order is ascending design address.
    function automatic logic [ADDR_W-1:0] lowest_set(input logic [NUM_DESIGNS-1:0] vec);
        logic [ADDR_W-1:0] idx;
        idx = {ADDR_W{1'b0}};
        for (int i = NUM_DESIGNS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ADDR_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Wishbone handshake and decoded strobes
    logic                   ack_q;
    logic [31:0]            dat_q;
    logic [31:0]            rdata_s;
    logic                   wb_req_s;
    logic                   wb_wr_s;
    logic                   wb_rd_s;
    logic [2:0]             wb_off_s;
    logic                   start_s;
    logic                   abort_s;
    logic                   sig_rd_s;
    logic                   busy_s;
    logic                   unused_s;

    // Configuration registers
    logic [NUM_DESIGNS-1:0] mask_q, mask_d;
    logic [7:0]             rstc_q, rstc_d;
    logic [CNT_W-1:0]       step_q, step_d;
    logic [IO_W-1:0]        stim_q, stim_d;

    // Sequencer state
    state_t                 state_q, state_d;
    logic [NUM_DESIGNS-1:0] pending_q, pending_d;
    logic [ADDR_W-1:0]      cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             rstc_lat_q, rstc_lat_d;
    logic [CNT_W-1:0]       step_lat_q, step_lat_d;
    logic [31:0]            misr_q, misr_d;
    logic [31:0]            misr_upd_s;
    logic [31:0]            sig_q, sig_d;
    logic                   sig_valid_q, sig_valid_d;
    logic                   done_q, done_d;
    logic                   ovr_en_q, ovr_en_d;
    logic                   ovr_rst_q, ovr_rst_d;
    logic                   ovr_clk_q, ovr_clk_d;
    logic [ADDR_W-1:0]      ovr_addr_q, ovr_addr_d;

    assign wb_req_s = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wb_wr_s  = wb_req_s & wbs_we_i;
    assign wb_rd_s  = wb_req_s & ~wbs_we_i;
    assign wb_off_s = wbs_adr_i[4:2];
    assign start_s  = wb_wr_s & (wb_off_s == 3'd0) & wbs_dat_i[0];
    assign abort_s  = wb_wr_s & (wb_off_s == 3'd0) & wbs_dat_i[1];
    assign sig_rd_s = wb_rd_s & (wb_off_s == 3'd6);
    assign busy_s   = (state_q != ST_IDLE);
    assign unused_s = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i[31:IO_W]};

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign ovr_en_o   = ovr_en_q;
    assign ovr_step_o = ovr_en_q;
    assign ovr_rst_o  = ovr_rst_q;
    assign ovr_clk_o  = ovr_clk_q;
    assign ovr_addr_o = ovr_addr_q;
    assign ovr_io_o   = stim_q;
    assign done_o     = done_q;

    // Configuration writes; dropped while a sequence is running.
    always_comb begin
        mask_d = mask_q;
        rstc_d = rstc_q;
        step_d = step_q;
        stim_d = stim_q;
        if (wb_wr_s && !busy_s) begin
            case (wb_off_s)
                3'd1:    mask_d = wbs_dat_i[NUM_DESIGNS-1:0];
                3'd2:    rstc_d = wbs_dat_i[7:0];
                3'd3:    step_d = wbs_dat_i[CNT_W-1:0];
                3'd4:    stim_d = wbs_dat_i[IO_W-1:0];
                default: mask_d = mask_q;
            endcase
        end else begin
            mask_d = mask_q;
        end
    end

    // Read data mux; the signature read sees a signature completing this cycle.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (wb_off_s)
            3'd0:    rdata_s = {30'd0, busy_s, done_q};
            3'd1:    rdata_s = {{(32-NUM_DESIGNS){1'b0}}, mask_q};
            3'd2:    rdata_s = {24'd0, rstc_q};
            3'd3:    rdata_s = {{(32-CNT_W){1'b0}}, step_q};
            3'd4:    rdata_s = {{(32-IO_W){1'b0}}, stim_q};
            3'd5:    rdata_s = {{(32-ADDR_W-4){1'b0}}, sig_valid_q, cur_addr_q, state_q};
            3'd6:    rdata_s = sig_d;
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    // Sequencer next-state and override output values.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cur_addr_d  = cur_addr_q;
        cnt_d       = cnt_q;
        rstc_lat_d  = rstc_lat_q;
        step_lat_d  = step_lat_q;
        misr_d      = misr_q;
        misr_upd_s  = misr_q;
        sig_d       = sig_q;
        sig_valid_d = sig_valid_q;
        done_d      = done_q;
        ovr_en_d    = ovr_en_q;
        ovr_rst_d   = ovr_rst_q;
        ovr_clk_d   = ovr_clk_q;
        ovr_addr_d  = ovr_addr_q;

        if (abort_s) begin
            state_d    = ST_IDLE;
            cnt_d      = {CNT_W{1'b0}};
            done_d     = 1'b1;
            ovr_en_d   = 1'b0;
            ovr_rst_d  = 1'b0;
            ovr_clk_d  = 1'b0;
            ovr_addr_d = {ADDR_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_d    = ST_SCAN;
                        pending_d  = mask_q;
                        done_d     = 1'b0;
                        rstc_lat_d = rstc_q;
                        step_lat_d = step_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (pending_q != {NUM_DESIGNS{1'b0}}) begin
                        state_d    = ST_SELECT;
                        cur_addr_d = lowest_set(pending_q);
                        pending_d  = pending_q & (pending_q - {{(NUM_DESIGNS-1){1'b0}}, 1'b1});
                        cnt_d      = {CNT_W{1'b0}};
                        ovr_en_d   = 1'b1;
                        ovr_rst_d  = 1'b1;
                        ovr_clk_d  = 1'b0;
                        ovr_addr_d = lowest_set(pending_q);
                    end else begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                        ovr_en_d   = 1'b0;
                        ovr_rst_d  = 1'b0;
                        ovr_clk_d  = 1'b0;
                        ovr_addr_d = {ADDR_W{1'b0}};
                    end
                end
                ST_SELECT: begin
                    // Two cycles so the multiplexer's address register settles.
                    if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_RESET;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESET: begin
                    if (ovr_clk_q) begin
                        ovr_clk_d = 1'b0;
                        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (cnt_q == {{(CNT_W-8){1'b0}}, rstc_lat_q}) begin
                        state_d   = ST_RUN;
                        ovr_rst_d = 1'b0;
                        cnt_d     = {CNT_W{1'b0}};
                        misr_d    = 32'hFFFF_FFFF;
                    end else begin
                        ovr_clk_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ovr_clk_q) begin
                        ovr_clk_d = 1'b0;
                        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        // Low cycle after a completed pulse: capture the design outputs.
                        if (cnt_q != {CNT_W{1'b0}}) begin
                            misr_upd_s = misr_step(misr_q, dso_cap_i);
                        end else begin
                            misr_upd_s = misr_q;
                        end
                        misr_d = misr_upd_s;
                        if (cnt_q == step_lat_q) begin
                            state_d     = ST_HOLD;
                            sig_d       = misr_upd_s;
                            sig_valid_d = 1'b1;
                            ovr_rst_d   = 1'b1;
                        end else begin
                            ovr_clk_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!sig_valid_q || sig_rd_s) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    ovr_en_d  = 1'b0;
                    ovr_rst_d = 1'b0;
                    ovr_clk_d = 1'b0;
                end
            endcase
        end

        if (sig_rd_s) begin
            sig_valid_d = 1'b0;
        end else begin
            sig_valid_d = sig_valid_d;
        end
    end

    // Wishbone ack and registered read data.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0000_0000;
        end else begin
            ack_q <= wb_req_s;
            dat_q <= wb_rd_s ? rdata_s : 32'h0000_0000;
        end
    end

    // Configuration register storage.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            mask_q <= {NUM_DESIGNS{1'b0}};
            rstc_q <= 8'd1;
            step_q <= {{(CNT_W-1){1'b0}}, 1'b1};
            stim_q <= {IO_W{1'b0}};
        end else begin
            mask_q <= mask_d;
            rstc_q <= rstc_d;
            step_q <= step_d;
            stim_q <= stim_d;
        end
    end

    // Sequencer state and override output registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            pending_q   <= {NUM_DESIGNS{1'b0}};
            cur_addr_q  <= {ADDR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rstc_lat_q  <= 8'd0;
            step_lat_q  <= {CNT_W{1'b0}};
            misr_q      <= 32'h0000_0000;
            sig_q       <= 32'h0000_0000;
            sig_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ovr_en_q    <= 1'b0;
            ovr_rst_q   <= 1'b0;
            ovr_clk_q   <= 1'b0;
            ovr_addr_q  <= {ADDR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_addr_q  <= cur_addr_d;
            cnt_q       <= cnt_d;
            rstc_lat_q  <= rstc_lat_d;
            step_lat_q  <= step_lat_d;
            misr_q      <= misr_d;
            sig_q       <= sig_d;
            sig_valid_q <= sig_valid_d;
            done_q      <= done_d;
            ovr_en_q    <= ovr_en_d;
            ovr_rst_q   <= ovr_rst_d;
            ovr_clk_q   <= ovr_clk_d;
            ovr_addr_q  <= ovr_addr_d;
        end
    end

endmodule

// File: tb/tb_design_bist_sequencer.sv
// Directed self-checking bench for design_bist_sequencer.
module tb_design_bist_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        ovr_en;
    logic        ovr_rst;
    logic        ovr_step;
    logic        ovr_clk;
    logic [3:0]  ovr_addr;
    logic [26:0] ovr_io;
    logic [26:0] cap;
    logic        done;

    int checks   = 0;
    int failures = 0;

    design_bist_sequencer dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_dat_o  (dat_o),
        .wbs_we_i   (we),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_ack_o  (ack),
        .ovr_en_o   (ovr_en),
        .ovr_rst_o  (ovr_rst),
        .ovr_step_o (ovr_step),
        .ovr_clk_o  (ovr_clk),
        .ovr_addr_o (ovr_addr),
        .ovr_io_o   (ovr_io),
        .dso_cap_i  (cap),
        .done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  off;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    // Reference MISR step: CRC-32 feedback shift, then XOR of the sample.
    function automatic logic [31:0] misr_m(input logic [31:0] s, input logic [26:0] c);
        logic [31:0] r;
        r = {s[30:0], 1'b0};
        if (s[31]) r = r ^ 32'h04C11DB7;
        return r ^ {5'd0, c};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [2:0] off, input logic w, input logic [31:0] wd,
                           output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {27'd0, off, 2'b00}; dat_i = wd;
        @(negedge clk);
        chk("wb_ack", {31'd0, ack}, 32'd1);
        rd = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [2:0] off, input logic [31:0] wd);
        logic [31:0] d;
        wb_xfer(off, 1'b1, wd, d);
    endtask

    task automatic wb_rd_chk(input string nm, input logic [2:0] off, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(off, 1'b0, 32'd0, d);
        chk(nm, d, exp);
    endtask

    // Poll STATUS until sig_valid, bounded.
    task automatic wait_hold(output logic [31:0] st);
        logic [31:0] d;
        bit ok;
        ok = 1'b0;
        d  = 32'd0;
        for (int i = 0; i < 80 && !ok; i++) begin
            wb_xfer(3'd5, 1'b0, 32'd0, d);
            if (d[7]) ok = 1'b1;
        end
        if (!ok) begin
            failures++;
            $display("FAIL hold_timeout actual=%h required=sig_valid", d);
        end
        st = d;
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] rd;
        logic [31:0] exp_sig;
        int rst_pulses;
        int run_pulses;
        int addr_bad;
        int pulses;
        bit found;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'd0; dat_i = 32'd0; cap = 27'd0;
        repeat (3) @(negedge clk);
        chk("rst_en",   {31'd0, ovr_en},   32'd0);
        chk("rst_rst",  {31'd0, ovr_rst},  32'd0);
        chk("rst_clk",  {31'd0, ovr_clk},  32'd0);
        chk("rst_step", {31'd0, ovr_step}, 32'd0);
        chk("rst_addr", {28'd0, ovr_addr}, 32'd0);
        chk("rst_done", {31'd0, done},     32'd0);
        chk("rst_ack",  {31'd0, ack},      32'd0);
        rst_n = 1'b1;

        // Register access table
        vecs[0]  = '{3'd0, 1'b0, 32'd0, 32'd0};
        vecs[1]  = '{3'd1, 1'b0, 32'd0, 32'd0};
        vecs[2]  = '{3'd2, 1'b0, 32'd0, 32'd1};
        vecs[3]  = '{3'd3, 1'b0, 32'd0, 32'd1};
        vecs[4]  = '{3'd4, 1'b0, 32'd0, 32'd0};
        vecs[5]  = '{3'd5, 1'b0, 32'd0, 32'd0};
        vecs[6]  = '{3'd6, 1'b0, 32'd0, 32'd0};
        vecs[7]  = '{3'd7, 1'b0, 32'd0, 32'd0};
        vecs[8]  = '{3'd1, 1'b1, 32'hFFFFFFFF, 32'd0};
        vecs[9]  = '{3'd3, 1'b1, 32'd5, 32'd0};
        vecs[10] = '{3'd4, 1'b1, 32'h00ABCDEF, 32'd0};
        vecs[11] = '{3'd2, 1'b1, 32'h000001FF, 32'd0};
        vecs[12] = '{3'd1, 1'b0, 32'd0, 32'h00000FFF};
        vecs[13] = '{3'd3, 1'b0, 32'd0, 32'd5};
        vecs[14] = '{3'd4, 1'b0, 32'd0, 32'h00ABCDEF};
        vecs[15] = '{3'd2, 1'b0, 32'd0, 32'h000000FF};
        vecs[16] = '{3'd7, 1'b1, 32'hDEADBEEF, 32'd0};
        vecs[17] = '{3'd7, 1'b0, 32'd0, 32'd0};
        for (int i = 0; i < 18; i++) begin
            wb_xfer(vecs[i].off, vecs[i].wr, 32'(vecs[i].wd), rd);
            if (!vecs[i].wr) chk($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
        end
        @(negedge clk);
        chk("ack_one_cycle", {31'd0, ack}, 32'd0);
        chk("io_is_stim", {5'd0, ovr_io}, 32'h00ABCDEF);
        chk("idle_no_en", {31'd0, ovr_en}, 32'd0);

        // Single design: MASK=0x004, RSTC=2, STEP=3, zero capture
        wb_wr(3'd1, 32'h004); wb_wr(3'd2, 32'd2); wb_wr(3'd3, 32'd3);
        wb_wr(3'd0, 32'd1);
        rst_pulses = 0; run_pulses = 0; addr_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ovr_en && (ovr_addr != 4'd2 || !ovr_step)) addr_bad++;
            if (ovr_clk && ovr_rst)  rst_pulses++;
            if (ovr_clk && !ovr_rst) run_pulses++;
        end
        chk("single_addr", addr_bad, 32'd0);
        chk("single_rst_pulses", rst_pulses, 32'd2);
        chk("single_run_pulses", run_pulses, 32'd3);
        chk("single_hold_en", {31'd0, ovr_en}, 32'd1);
        wb_rd_chk("single_status", 3'd5, 32'h95);
        wb_rd_chk("single_sig", 3'd6, 32'hE1B8AFFD);
        @(negedge clk);
        chk("single_done", {31'd0, done}, 32'd1);
        wb_rd_chk("single_ctrl", 3'd0, 32'd1);

        // Multi design: designs 0,5,7 with RSTC=1, STEP=2
        cap = 27'h5A5A5A5;
        exp_sig = misr_m(misr_m(32'hFFFFFFFF, cap), cap);
        wb_wr(3'd1, 32'h0A1); wb_wr(3'd2, 32'd1); wb_wr(3'd3, 32'd2);
        wb_wr(3'd0, 32'd1);
        wait_hold(st);
        chk("multi0_status", st, 32'h85);
        repeat (20) @(negedge clk);
        wb_rd_chk("multi0_paused", 3'd5, 32'h85);
        wb_rd_chk("multi0_sig", 3'd6, exp_sig);
        @(negedge clk);
        chk("multi0_not_done", {31'd0, done}, 32'd0);
        wait_hold(st);
        chk("multi5_status", st, 32'hAD);
        wb_rd_chk("multi5_sig", 3'd6, exp_sig);
        @(negedge clk);
        chk("multi5_not_done", {31'd0, done}, 32'd0);
        wait_hold(st);
        chk("multi7_status", st, 32'hBD);
        wb_rd_chk("multi7_sig", 3'd6, exp_sig);
        @(negedge clk);
        chk("multi_done", {31'd0, done}, 32'd1);

        // MASK=0: done within 3 cycles, SIG unchanged
        wb_wr(3'd1, 32'd0);
        wb_wr(3'd0, 32'd1);
        chk("mask0_done_cleared", {31'd0, done}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        chk("mask0_done", {31'd0, found}, 32'd1);
        wb_rd_chk("mask0_sig_kept", 3'd6, exp_sig);

        // STEP=0: signature is the MISR seed
        cap = 27'd0;
        wb_wr(3'd1, 32'd1); wb_wr(3'd2, 32'd0); wb_wr(3'd3, 32'd0);
        wb_wr(3'd0, 32'd1);
        wait_hold(st);
        chk("step0_status", st, 32'h85);
        wb_rd_chk("step0_sig", 3'd6, 32'hFFFFFFFF);
        @(negedge clk);

        // Start and config writes while busy are ignored
        wb_wr(3'd1, 32'h002); wb_wr(3'd2, 32'd3); wb_wr(3'd3, 32'd10);
        wb_wr(3'd0, 32'd1);
        wb_wr(3'd1, 32'h003);
        wb_wr(3'd0, 32'd1);
        wait_hold(st);
        chk("busy_status", st, 32'h8D);
        exp_sig = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) exp_sig = misr_m(exp_sig, 27'd0);
        wb_rd_chk("busy_sig", 3'd6, exp_sig);
        @(negedge clk);
        chk("busy_done", {31'd0, done}, 32'd1);
        wb_rd_chk("busy_mask_kept", 3'd1, 32'h002);

        // Abort during run pulse 2 of 10
        wb_wr(3'd1, 32'd1); wb_wr(3'd2, 32'd0); wb_wr(3'd3, 32'd10);
        wb_wr(3'd0, 32'd1);
        pulses = 0;
        for (int i = 0; i < 200 && pulses < 2; i++) begin
            @(negedge clk);
            if (ovr_en && ovr_clk && !ovr_rst) pulses++;
        end
        if (pulses < 2) begin
            failures++;
            $display("FAIL abort_pulse_timeout actual=%0d required=2", pulses);
        end else begin
            cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd0; dat_i = 32'd2;
            @(negedge clk);
            chk("abort_ack",  {31'd0, ack},     32'd1);
            chk("abort_en",   {31'd0, ovr_en},  32'd0);
            chk("abort_clk",  {31'd0, ovr_clk}, 32'd0);
            chk("abort_done", {31'd0, done},    32'd1);
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
            wb_rd_chk("abort_status", 3'd5, 32'h00);
            wb_rd_chk("abort_ctrl", 3'd0, 32'd1);
        end

        // Async reset in the RESET state, then a clean run with defaults
        wb_wr(3'd1, 32'd1); wb_wr(3'd2, 32'd20); wb_wr(3'd3, 32'd1);
        wb_wr(3'd0, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ovr_rst && ovr_clk) found = 1'b1;
        end
        chk("areset_reached_reset", {31'd0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_en",   {31'd0, ovr_en},   32'd0);
        chk("areset_rst",  {31'd0, ovr_rst},  32'd0);
        chk("areset_clk",  {31'd0, ovr_clk},  32'd0);
        chk("areset_step", {31'd0, ovr_step}, 32'd0);
        chk("areset_addr", {28'd0, ovr_addr}, 32'd0);
        chk("areset_io",   {5'd0, ovr_io},    32'd0);
        chk("areset_done", {31'd0, done},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_rd_chk("areset_rstc", 3'd2, 32'd1);
        wb_rd_chk("areset_step_reg", 3'd3, 32'd1);
        wb_rd_chk("areset_ctrl", 3'd0, 32'd0);
        cap = 27'd3;
        wb_wr(3'd1, 32'h008);
        wb_wr(3'd0, 32'd1);
        wait_hold(st);
        chk("rerun_status", st, 32'h9D);
        wb_rd_chk("rerun_sig", 3'd6, 32'hFB3EE24A);
        @(negedge clk);
        chk("rerun_done", {31'd0, done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
